// File: rtl/mips_decls_p.sv
// Shared MIPS multicycle encodings: instruction fields, ALU op classes, controller states.
package mips_decls_p;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;

  localparam opcode_t OpRtype = 6'b000000;
  localparam opcode_t OpLw    = 6'b100011;
  localparam opcode_t OpSw    = 6'b101011;
  localparam opcode_t OpBeq   = 6'b000100;
  localparam opcode_t OpAddi  = 6'b001000;
  localparam opcode_t OpJ     = 6'b000010;
  localparam opcode_t OpJal   = 6'b000011;

  localparam funct_t FnAdd = 6'b100000;
  localparam funct_t FnSub = 6'b100010;
  localparam funct_t FnAnd = 6'b100100;
  localparam funct_t FnOr  = 6'b100101;
  localparam funct_t FnSlt = 6'b101010;
  localparam funct_t FnJr  = 6'b001000;

  // AluOpNone marks states that do not use the ALU; it decodes to 000.
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpNone  = 2'b11
  } aluop_t;

  localparam logic [2:0] AluCtlAnd = 3'b000;
  localparam logic [2:0] AluCtlOr  = 3'b001;
  localparam logic [2:0] AluCtlAdd = 3'b010;
  localparam logic [2:0] AluCtlSub = 3'b110;
  localparam logic [2:0] AluCtlSlt = 3'b111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecute,
    StAluWb,
    StBranch,
    StAddiExec,
    StAddiWb,
    StJump,
    StJal,
    StJr
  } mc_state_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory control bundle. The controller is the master.
interface mc_controller_if;

  mips_decls_p::opcode_t opcode;
  mips_decls_p::funct_t  funct;
  logic                  zero;
  logic                  mem_ready;

  logic       mem_req;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       pcen;
  logic [1:0] regdst;
  logic [1:0] memtoreg;
  logic [1:0] pcsrc;
  logic [1:0] alusrcb;
  logic       alusrca;
  logic [2:0] alucontrol;
  logic       illegal_op;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, iord, irwrite, memwrite, regwrite, pcen,
           regdst, memtoreg, pcsrc, alusrcb, alusrca, alucontrol, illegal_op
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, iord, irwrite, memwrite, regwrite, pcen,
           regdst, memtoreg, pcsrc, alusrcb, alusrca, alucontrol, illegal_op
  );

endinterface

// File: rtl/aludec.sv
// ALU control decoder: maps the op class (and funct for R-type) to the 3-bit ALU code.
module aludec
  import mips_decls_p::*;
(
  input  funct_t     funct_i,
  input  aluop_t     aluop_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = 3'b000;
    unique case (aluop_i)
      AluOpAdd:   alucontrol_o = AluCtlAdd;
      AluOpSub:   alucontrol_o = AluCtlSub;
      AluOpFunct: begin
        case (funct_i)
          FnAdd:   alucontrol_o = AluCtlAdd;
          FnSub:   alucontrol_o = AluCtlSub;
          FnAnd:   alucontrol_o = AluCtlAnd;
          FnOr:    alucontrol_o = AluCtlOr;
          FnSlt:   alucontrol_o = AluCtlSlt;
          default: alucontrol_o = 3'b000;
        endcase
      end
      AluOpNone:  alucontrol_o = 3'b000;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute with
// unbounded memory wait states. All outputs are forced low while reset is high.
module mc_controller
  import mips_decls_p::*;
(
  input logic             clk,
  input logic             reset,
  mc_controller_if.master bus
);

  mc_state_t  state_q, state_d;
  aluop_t     aluop;
  logic [2:0] alucontrol;
  logic       pcwrite, branch;
  logic       mem_req, iord, irwrite, memwrite, regwrite, alusrca, illegal_op;
  logic [1:0] regdst, memtoreg, pcsrc, alusrcb;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    aluop      = AluOpNone;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    mem_req    = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    illegal_op = 1'b0;
    regdst     = 2'b00;
    memtoreg   = 2'b00;
    pcsrc      = 2'b00;
    alusrcb    = 2'b00;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          irwrite = 1'b1;
          alusrcb = 2'b01;
          aluop   = AluOpAdd;
          pcwrite = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        alusrcb = 2'b11;
        aluop   = AluOpAdd;
        case (bus.opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = (bus.funct == FnJr) ? StJr : StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiExec;
          OpJ:        state_d = StJump;
          OpJal:      state_d = StJal;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = AluOpAdd;
        state_d = (bus.opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        memtoreg = 2'b01;
        regwrite = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (bus.mem_ready) state_d = StFetch;
      end
      StExecute: begin
        alusrca = 1'b1;
        aluop   = AluOpFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        regdst   = 2'b01;
        regwrite = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        alusrca = 1'b1;
        aluop   = AluOpSub;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = StFetch;
      end
      StAddiExec: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = AluOpAdd;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        regwrite = 1'b1;
        state_d  = StFetch;
      end
      StJump: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = StFetch;
      end
      // Link value is the pre-edge PC, which already holds PC+4 after fetch.
      StJal: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
        regwrite = 1'b1;
        state_d  = StFetch;
      end
      StJr: begin
        pcsrc   = 2'b11;
        pcwrite = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  aludec u_aludec (
    .funct_i      (bus.funct),
    .aluop_i      (aluop),
    .alucontrol_o (alucontrol)
  );

  assign bus.mem_req    = mem_req & ~reset;
  assign bus.iord       = iord & ~reset;
  assign bus.irwrite    = irwrite & ~reset;
  assign bus.memwrite   = memwrite & ~reset;
  assign bus.regwrite   = regwrite & ~reset;
  assign bus.pcen       = (pcwrite | (branch & bus.zero)) & ~reset;
  assign bus.regdst     = reset ? 2'b00 : regdst;
  assign bus.memtoreg   = reset ? 2'b00 : memtoreg;
  assign bus.pcsrc      = reset ? 2'b00 : pcsrc;
  assign bus.alusrcb    = reset ? 2'b00 : alusrcb;
  assign bus.alusrca    = alusrca & ~reset;
  assign bus.alucontrol = reset ? 3'b000 : alucontrol;
  assign bus.illegal_op = illegal_op & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: random instruction stream with random memory waits,
// expected per-cycle control words queued by the stimulus and checked by a monitor.
module tb_mc_controller
  import mips_decls_p::*;
;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       pcen;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic       alusrca;
    logic [2:0] alucontrol;
    logic       illegal_op;
  } ctl_t;

  typedef enum int {
    PhFetch, PhDecode, PhMemAdr, PhMemRd, PhMemWb, PhMemWr, PhExec, PhAluWb,
    PhBranch, PhAddiExec, PhAddiWb, PhJump, PhJal, PhJr, PhReset
  } phase_e;

  typedef struct {
    ctl_t   w;
    phase_e ph;
  } exp_t;

  logic clk;
  logic reset;
  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t    exp_q[$];
  phase_e  plan_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  opcode_t cur_op   = OpRtype;
  funct_t  cur_fn   = FnAdd;
  int      zero_mode = 2;

  function automatic logic is_legal(opcode_t op);
    return op inside {OpRtype, OpLw, OpSw, OpBeq, OpAddi, OpJ, OpJal};
  endfunction

  function automatic logic [2:0] funct_alu(funct_t fn);
    case (fn)
      FnAdd:   return 3'b010;
      FnSub:   return 3'b110;
      FnAnd:   return 3'b000;
      FnOr:    return 3'b001;
      FnSlt:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Spec table of control outputs active in each phase; everything unlisted is 0.
  function automatic ctl_t exp_word(phase_e ph, logic rdy, logic z);
    ctl_t w;
    w = '0;
    case (ph)
      PhFetch: begin
        w.mem_req = 1'b1;
        if (rdy) begin
          w.irwrite = 1'b1; w.alusrcb = 2'b01; w.alucontrol = 3'b010; w.pcen = 1'b1;
        end
      end
      PhDecode: begin
        w.alusrcb = 2'b11; w.alucontrol = 3'b010; w.illegal_op = !is_legal(cur_op);
      end
      PhMemAdr:   begin w.alusrca = 1'b1; w.alusrcb = 2'b10; w.alucontrol = 3'b010; end
      PhMemRd:    begin w.mem_req = 1'b1; w.iord = 1'b1; end
      PhMemWb:    begin w.memtoreg = 2'b01; w.regwrite = 1'b1; end
      PhMemWr:    begin w.mem_req = 1'b1; w.iord = 1'b1; w.memwrite = 1'b1; end
      PhExec:     begin w.alusrca = 1'b1; w.alucontrol = funct_alu(cur_fn); end
      PhAluWb:    begin w.regdst = 2'b01; w.regwrite = 1'b1; end
      PhBranch: begin
        w.alusrca = 1'b1; w.alucontrol = 3'b110; w.pcsrc = 2'b01; w.pcen = z;
      end
      PhAddiExec: begin w.alusrca = 1'b1; w.alusrcb = 2'b10; w.alucontrol = 3'b010; end
      PhAddiWb:   w.regwrite = 1'b1;
      PhJump:     begin w.pcsrc = 2'b10; w.pcen = 1'b1; end
      PhJal: begin
        w.pcsrc = 2'b10; w.pcen = 1'b1; w.regdst = 2'b10; w.memtoreg = 2'b10;
        w.regwrite = 1'b1;
      end
      PhJr:       begin w.pcsrc = 2'b11; w.pcen = 1'b1; end
      default:    w = '0;
    endcase
    return w;
  endfunction

  task automatic plan(input opcode_t op, input funct_t fn);
    plan_q = {PhFetch, PhDecode};
    case (op)
      OpLw:    plan_q = {plan_q, PhMemAdr, PhMemRd, PhMemWb};
      OpSw:    plan_q = {plan_q, PhMemAdr, PhMemWr};
      OpRtype: plan_q = (fn == FnJr) ? {plan_q, PhJr} : {plan_q, PhExec, PhAluWb};
      OpBeq:   plan_q.push_back(PhBranch);
      OpAddi:  plan_q = {plan_q, PhAddiExec, PhAddiWb};
      OpJ:     plan_q.push_back(PhJump);
      OpJal:   plan_q.push_back(PhJal);
      default: ;
    endcase
  endtask

  // One clock cycle: drive inputs just after the edge and queue the expected outputs.
  task automatic cyc(input logic rst, input logic rdy, input phase_e ph);
    logic z;
    @(posedge clk);
    #1;
    z = (zero_mode == 2) ? 1'($urandom % 2) : (zero_mode == 1);
    reset         = rst;
    bus.mem_ready = rdy;
    bus.zero      = z;
    bus.opcode    = cur_op;
    bus.funct     = cur_fn;
    exp_q.push_back('{w: rst ? ctl_t'('0) : exp_word(ph, rdy, z), ph: rst ? PhReset : ph});
  endtask

  // waits < 0 picks random wait counts; abort_wr resets during a stalled MEMWR.
  task automatic run_instr(input opcode_t op, input funct_t fn, input int waits,
                           input logic abort_wr);
    int n;
    cur_op = op;
    cur_fn = fn;
    plan(op, fn);
    foreach (plan_q[i]) begin
      if (plan_q[i] inside {PhFetch, PhMemRd, PhMemWr}) begin
        if (plan_q[i] == PhFetch) n = (waits < 0) ? int'($urandom_range(0, 2)) : 0;
        else n = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
        if (abort_wr && plan_q[i] == PhMemWr) begin
          repeat (n + 1) cyc(1'b0, 1'b0, plan_q[i]);
          cyc(1'b1, 1'b0, PhReset);
          return;
        end
        repeat (n) cyc(1'b0, 1'b0, plan_q[i]);
        cyc(1'b0, 1'b1, plan_q[i]);
      end else begin
        cyc(1'b0, 1'($urandom % 2), plan_q[i]);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    ctl_t act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {bus.mem_req, bus.iord, bus.irwrite, bus.memwrite, bus.regwrite, bus.pcen,
             bus.regdst, bus.memtoreg, bus.pcsrc, bus.alusrcb, bus.alusrca,
             bus.alucontrol, bus.illegal_op};
      n_checks++;
      if (act !== e.w) begin
        n_fail++;
        $display("FAIL %s @%0t: got %05h required %05h (op=%02h fn=%02h)",
                 e.ph.name(), $time, act, e.w, bus.opcode, bus.funct);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  opcode_t legal_ops[7] = '{OpRtype, OpLw, OpSw, OpBeq, OpAddi, OpJ, OpJal};
  funct_t  r_fns[6]     = '{FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnJr};

  initial begin
    opcode_t op;
    reset         = 1'b1;
    bus.opcode    = OpRtype;
    bus.funct     = FnAdd;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    cyc(1'b1, 1'b0, PhReset);
    cyc(1'b1, 1'b1, PhReset);

    run_instr(OpLw, FnAdd, 3, 1'b0);
    zero_mode = 1; run_instr(OpBeq, FnAdd, 0, 1'b0);
    zero_mode = 0; run_instr(OpBeq, FnAdd, 0, 1'b0);
    zero_mode = 2;
    run_instr(OpJal, FnAdd, 0, 1'b0);
    run_instr(OpRtype, FnJr, 0, 1'b0);
    run_instr(OpRtype, FnOr, 0, 1'b0);
    run_instr(6'b111111, FnAdd, 0, 1'b0);
    run_instr(OpSw, FnAdd, 1, 1'b1);
    run_instr(OpAddi, FnAdd, 0, 1'b0);
    run_instr(OpJ, FnAdd, 0, 1'b0);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = opcode_t'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 6)];
      end
      run_instr(op, r_fns[$urandom_range(0, 5)], -1, ($urandom_range(0, 7) == 0));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected words left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The module SHALL have no parameters; all encodings SHALL come from mips_decls_p.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  mips_decls_p::opcode_t  opcode field from the instruction register.
REQ-005 funct  input  mips_decls_p::funct_t  funct field from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  shared memory has completed the current access this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 irwrite, memwrite, regwrite  output  1 each  write enables.
REQ-011 pcen  output  1  PC register enable.
REQ-012 regdst, memtoreg, pcsrc, alusrcb  output  2 each  datapath mux selects.
REQ-013 alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-014 alucontrol  output  3  ALU operation code.
REQ-015 illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-016 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, JAL, JR.
- Listed outputs are active in the state shown.
- Unlisted outputs are 0.
REQ-017 FETCH SHALL drive mem_req=1 and iord=0.
- If mem_ready=1: irwrite=1, alusrcb=01, ALU add, pcsrc=00, PC write; next state DECODE.
- If mem_ready=0: remain in FETCH with irwrite=0 and no PC write.
REQ-018 DECODE SHALL drive alusrcb=11 with ALU add (branch target) and go to the next state by opcode:
- LW or SW -> MEMADR
- RTYPE with funct JR -> JR
- other RTYPE -> EXECUTE
- BEQ -> BRANCH
- ADDI -> ADDIEXEC
- J -> JUMP
- JAL -> JAL
- any other opcode -> FETCH, with illegal_op=1 for that cycle.
REQ-019 MEMADR SHALL drive alusrca=1, alusrcb=10, ALU add; next state MEMRD for LW, MEMWR for SW.
REQ-020 MEMRD SHALL drive mem_req=1 and iord=1, and hold until mem_ready=1, then go to MEMWB.
REQ-021 MEMWB SHALL drive regdst=00, memtoreg=01, regwrite=1, then go to FETCH.
REQ-022 MEMWR SHALL drive mem_req=1, iord=1 and memwrite=1, holding all three until mem_ready=1, then go to FETCH.
REQ-023 EXECUTE SHALL drive alusrca=1, alusrcb=00, aluop=10 (funct decode), then go to ALUWB.
REQ-024 ALUWB SHALL drive regdst=01 and regwrite=1.
REQ-025 BRANCH SHALL drive alusrca=1, aluop=01 (subtract) and pcsrc=01; pcen = branch & zero, evaluated combinationally in this state only.
REQ-026 ADDIEXEC SHALL drive alusrca=1, alusrcb=10, ALU add; ADDIWB SHALL drive regdst=00 and regwrite=1.
REQ-027 JUMP SHALL drive pcsrc=10 and PC write.
REQ-028 JAL SHALL drive pcsrc=10, PC write, regdst=10 (r31), memtoreg=10 (PC) and regwrite=1 in the same cycle; the register file SHALL receive the pre-edge PC, which is already PC+4.
REQ-029 JR SHALL drive pcsrc=11 (register A) and PC write.
REQ-030 ALUWB, BRANCH, ADDIWB, JUMP, JAL and JR SHALL each return to FETCH after one cycle.
REQ-031 pcen SHALL equal (PC write) | (branch & zero).
REQ-032 alucontrol SHALL be: 010 for add, 110 for subtract, and the funct decode for aluop=10 (add 010, sub 110, and 000, or 001, slt 111).
REQ-033 Memory wait states SHALL be unbounded; no write enable other than memwrite in MEMWR SHALL be asserted while waiting.

Reset
REQ-034 reset=1 at a clock edge SHALL load FETCH, aborting any instruction in progress.
REQ-035 While reset=1, all outputs SHALL be forced to 0 regardless of state, so no write occurs mid-reset.

Structure
REQ-036 The state enum mc_state_t and the aluop encodings SHALL be declared in mips_decls_p alongside opcode_t and funct_t.
REQ-037 ALU decoding SHALL use one sub-module instance of the existing aludec; next-state and output logic SHALL be blocking combinational logic.

Verification
REQ-038 LW with mem_ready held low 3 cycles in MEMRD -> FETCH, DECODE, MEMADR, MEMRD x4, MEMWB; exactly one regwrite pulse, with memtoreg=01.
REQ-039 BEQ with zero=1 -> pcen=1 and pcsrc=01 in BRANCH; with zero=0 -> pcen=0; both cases return to FETCH.
REQ-040 JAL -> one JAL-state cycle with regdst=10, memtoreg=10, regwrite=1, pcsrc=10, pcen=1.
REQ-041 RTYPE funct JR -> JR state with pcsrc=11 and pcen=1; RTYPE funct OR -> alucontrol=001 in EXECUTE.
REQ-042 Opcode 111111 -> illegal_op is a one-cycle pulse in DECODE, then FETCH; no write enables assert.
REQ-043 reset asserted during MEMWR with mem_ready=0 -> memwrite=0 that cycle and state FETCH on the next cycle.
